led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
Parametrised successor to the switch-driven LED blink controller. A programmable divider generates step ticks at one of several switch-selected rates. A pattern engine advances an LED_W-wide pattern on each tick. Sits between the board switches/clock and the LED bank. Replaces the fixed single-toggle mode clock with selectable patterns, clean restart on mode change, and a tick strobe for downstream logic.

Parameters:
LED_W, 16, number of LED outputs (>=2)
DIV1, 500, tick period in SCLK cycles for speed code 1
DIV2, 250, tick period in SCLK cycles for speed code 2
DIV3, 100, tick period in SCLK cycles for speed code 3
CNT_W, 10, divider counter width; must satisfy 2^CNT_W > max(DIV1,DIV2,DIV3)

Ports:
SCLK  in  1  system clock
RST_N  in  1  reset, asynchronous assert, active-low
SW  in  2  speed select: 0=stopped, 1..3 select DIV1..DIV3
PAT  in  2  pattern select: 0=run, 1=ping-pong, 2=fill, 3=count
LD  out  LED_W  LED drive
TICK  out  1  one-cycle strobe, high in the cycle LD advances

Behaviour:
- One clock, SCLK. Reset is asynchronous and active-low on RST_N. Reset values: LD=0, TICK=0, cnt=0, sw_q=0, pat_q=0, dir=up, load_pend=1.
- First edge after reset release: LD loads init(PAT), pat_q<=PAT, load_pend<=0; no tick that cycle.
- Divider, SW!=0: each cycle cnt++.
  - When cnt==DIV(SW)-1: cnt<=0 and TICK=1 that cycle (registered, aligned with the LD update).
  - Tick period is exactly DIV(SW) cycles.
- SW==0: cnt held at 0, TICK=0, LD frozen at its current value.
- SW change (SW!=sw_q): cnt<=0, sw_q<=SW, no tick that cycle. The first tick at the new rate occurs DIV(SW) cycles later.
- PAT change (PAT!=pat_q): LD<=init(PAT), dir<=up, cnt<=0, pat_q<=PAT, no tick.
- Priority, highest first: reset > load_pend / PAT change > SW change > tick.
- Patterns, applied on TICK:
  - 0 run: init 1. Rotate left; bit LED_W-1 wraps to bit 0.
  - 1 ping-pong: init 1, dir=up. Up: if LD[LED_W-1] then dir<=down and shift right, else shift left. Down: if LD[0] then dir<=up and shift left, else shift right. Period 2*(LED_W-1). Exactly one bit is set at all times.
  - 2 fill: init 0. If LD is all-ones then LD<=0, else LD<=(LD<<1)|1. Period LED_W+1.
  - 3 count: init 0. LD<=LD+1, wrapping modulo 2^LED_W.
- All LD/TICK outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds input DUTY[3:0] and a free-running 4-bit PWM counter pwm (reset 0, increments every SCLK).
  - LD = pattern & {LED_W{pwm<DUTY}}, registered with one cycle of latency.
  - DUTY=0 gives LD always 0; DUTY=15 gives on 15 of every 16 cycles.
  - The pattern state and TICK are unaffected by DUTY.
- Not defined: no DUTY port; LD = pattern register directly.

Decomposition:
- Package led_ctrl_pkg:
  - pattern enum (PAT_RUN, PAT_PINGPONG, PAT_FILL, PAT_COUNT);
  - speed code constants (SPD_STOP=0);
  - default DIV values;
  - init-value function init_pat(pat, width).
- Sub-module led_tick_gen: divider counter, SW edge detect, TICK generation. Ports SCLK, RST_N, SW, clr, TICK.
- Pattern engine and the optional PWM stay in the top module.

Test Plan:
- Reset with SW=1, PAT=0, release RST_N → LD=0x0001 on the first edge. TICK every 500 cycles, LD 0x0001→0x0002→0x0004. After 16 ticks LD=0x0001 again.
- SW=3, PAT=1, LED_W=16 → tick period 100. LD walks 0x0001→0x8000 in 15 ticks, then back to 0x0001 in 15 more; never 0 and never more than one bit set.
- SW=2, PAT=2 → LD 0x0000,0x0001,0x0003,…,0xFFFF, then 0x0000 on tick 17. SW set to 0 mid-sequence → LD frozen and TICK low for 1000 cycles.
- Change SW 1→3 at cnt=300 → no tick at the old rate; next TICK exactly 100 cycles after the change. Change SW on the same cycle as the terminal count → no TICK that cycle.
- PAT 3 at LD=0x0005, switch to PAT=0 → next cycle LD=0x0001, TICK=0, first tick DIV cycles later. Assert RST_N low mid-sequence → LD=0 and TICK=0 immediately (asynchronous).
- With LED_PWM_EN, PAT=0, DUTY=4 → LD nonzero in exactly 4 of every 16 cycles. DUTY=0 → LD=0 while TICK continues on schedule.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// led_ctrl_pkg: shared pattern/direction types, speed codes, default dividers and the pattern init helper
package led_ctrl_pkg;

    typedef enum logic [1:0] {PAT_RUN, PAT_PINGPONG, PAT_FILL, PAT_COUNT} pat_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    localparam logic [1:0] SPD_STOP = 2'd0;
    localparam logic [1:0] SPD_1    = 2'd1;
    localparam logic [1:0] SPD_2    = 2'd2;

    localparam int DEF_DIV1 = 500;
    localparam int DEF_DIV2 = 250;
    localparam int DEF_DIV3 = 100;
    localparam int MAX_W    = 64;

    // run and ping-pong start from a single lit LED, fill and count start dark
    function automatic logic [MAX_W-1:0] init_pat(pat_e pat, int width);
        return ((pat == PAT_RUN || pat == PAT_PINGPONG) && width > 0) ? MAX_W'(1) : '0;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: switch/LED bundle; DUTY exists only when LED_PWM_EN is defined
interface led_pattern_ctrl_if #(
    parameter int LED_W = 16
);
    logic [1:0]       SW;
    logic [1:0]       PAT;
    logic [LED_W-1:0] LD;
    logic             TICK;
`ifdef LED_PWM_EN
    logic [3:0]       DUTY;
    modport master (output SW, PAT, DUTY, input LD, TICK);
    modport slave  (input SW, PAT, DUTY, output LD, TICK);
`else
    modport master (output SW, PAT, input LD, TICK);
    modport slave  (input SW, PAT, output LD, TICK);
`endif
endinterface

// File: rtl/led_pattern_ctrl_tick_gen.sv
// led_tick_gen: speed-selected divider; TICK is the combinational step strobe for the current cycle
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3,
    parameter int CNT_W = 10
)(
    input  logic       SCLK,
    input  logic       RST_N,
    input  logic [1:0] SW,
    input  logic       clr,
    output logic       TICK
);

    logic [CNT_W-1:0] cnt, term;
    logic [1:0]       sw_q;

    assign term = SW == SPD_1 ? CNT_W'(DIV1 - 1) : SW == SPD_2 ? CNT_W'(DIV2 - 1) : CNT_W'(DIV3 - 1);
    assign TICK = !clr && SW == sw_q && SW != SPD_STOP && cnt == term;

    // restart the count on pattern load, rate change or stop; wrap on terminal count
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            sw_q <= SPD_STOP;
        end else begin
            sw_q <= SW;
            cnt  <= (clr || SW != sw_q || SW == SPD_STOP || TICK) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: tick-driven LED pattern engine; optional PWM dimming under LED_PWM_EN
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3,
    parameter int CNT_W = 10
)(
    input logic               SCLK,
    input logic               RST_N,
    led_pattern_ctrl_if.slave bus
);

    pat_e             pat_in, pat_q;
    dir_e             dir, dir_nxt;
    logic             load_pend, clr, tick_c, tick_q, turn, go_up;
    logic [LED_W-1:0] pat_r, pat_nxt;

    assign pat_in = pat_e'(bus.PAT);
    assign clr    = load_pend || pat_in != pat_q;

    led_tick_gen #(.DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .CNT_W(CNT_W)) u_tick (
        .SCLK (SCLK),
        .RST_N(RST_N),
        .SW   (bus.SW),
        .clr  (clr),
        .TICK (tick_c)
    );

    // one step of the selected pattern; ping-pong reverses when the lit bit reaches an end
    always_comb begin
        dir_nxt = dir;
        pat_nxt = pat_r;
        turn    = dir == DIR_UP ? pat_r[LED_W-1] : pat_r[0];
        go_up   = (dir == DIR_UP) ^ turn;
        case (pat_q)
            PAT_RUN:      pat_nxt = {pat_r[LED_W-2:0], pat_r[LED_W-1]};
            PAT_PINGPONG: begin
                dir_nxt = go_up ? DIR_UP : DIR_DOWN;
                pat_nxt = go_up ? pat_r << 1 : pat_r >> 1;
            end
            PAT_FILL:     pat_nxt = &pat_r ? '0 : {pat_r[LED_W-2:0], 1'b1};
            PAT_COUNT:    pat_nxt = pat_r + LED_W'(1);
        endcase
    end

    // pattern state: reload on start-up or pattern change, advance on tick
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            load_pend <= 1'b1;
            pat_q     <= PAT_RUN;
            dir       <= DIR_UP;
            pat_r     <= '0;
            tick_q    <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            tick_q    <= tick_c;
            if (clr) begin
                pat_q <= pat_in;
                dir   <= DIR_UP;
                pat_r <= LED_W'(init_pat(pat_in, LED_W));
            end else if (tick_c) begin
                dir   <= dir_nxt;
                pat_r <= pat_nxt;
            end
        end
    end

    assign bus.TICK = tick_q;

`ifdef LED_PWM_EN
    logic [3:0]       pwm;
    logic [LED_W-1:0] ld_q;

    // free-running PWM phase and gated LED register
    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm  <= '0;
            ld_q <= '0;
        end else begin
            pwm  <= pwm + 4'd1;
            ld_q <= pat_r & {LED_W{pwm < bus.DUTY}};
        end
    end

    assign bus.LD = ld_q;
`else
    assign bus.LD = pat_r;
`endif

endmodule
